ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 126 ++++++++++++
 tb/tb_ifetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch sequencer with a circular fetch queue and redirect handling
module ifetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  req_addr;
  logic [ADDR_W-1:0]  redir_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_nxt;
  logic               room;
  logic [ADDR_W-1:0]  redir_tgt;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  assign redir_tgt  = redirect_pc & ~ADDR_W'(3);

  // A redirect suppresses both queue operations so the flush wins.
  assign pop        = out_valid & out_ready & ~redirect_valid;
  assign push       = (state == S_REQ) & iresp_data_ok & ~redirect_valid;
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
  assign room       = (count_nxt < CNT_W'(DEPTH));

  assign ireq_valid = (state != S_IDLE);
  assign ireq_addr  = req_addr;
  assign out_valid  = (count != '0);
  assign out_pc     = pc_mem[head];
  assign out_instr  = instr_mem[head];

  // Fetch FSM plus queue pointer/count bookkeeping; a redirect flushes from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      req_addr <= RESET_PC;
      redir_pc <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (redirect_valid) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        count <= count_nxt;
        if (pop)  head <= head + PTR_W'(1);
        if (push) tail <= tail + PTR_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            req_addr <= redir_tgt;
            state    <= S_REQ;
          end else if (room) begin
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            if (iresp_data_ok) begin
              // Response completed this cycle, so the new target can be issued at once.
              req_addr <= redir_tgt;
            end else begin
              // Request still in flight: hold the bus address and remember the target.
              redir_pc <= redir_tgt;
              state    <= S_DISCARD;
            end
          end else if (iresp_data_ok) begin
            req_addr <= req_addr + ADDR_W'(4);
            state    <= room ? S_REQ : S_IDLE;
          end
        end
        S_DISCARD: begin
          if (redirect_valid) redir_pc <= redir_tgt;
          if (iresp_data_ok) begin
            req_addr <= redirect_valid ? redir_tgt : redir_pc;
            state    <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Queue storage is written at the tail on every accepted response.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= req_addr;
      instr_mem[tail] <= iresp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        dok = 1'b0;
  logic [31:0] idata;
  logic        rdv = 1'b0;
  logic [63:0] rpc = '0;
  logic        ov;
  logic        rdy = 1'b0;
  logic [63:0] opc;
  logic [31:0] oinstr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rdy;
    logic       ov;
    logic [7:0] pc_off;
    logic       iv;
    logic [7:0] ia_off;
  } vec_t;

  vec_t tbl [13];

  ifetch_queue #(
    .ADDR_W  (64),
    .INSTR_W (32),
    .DEPTH   (4),
    .RESET_PC(64'h8000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (dok),
    .iresp_data    (idata),
    .redirect_valid(rdv),
    .redirect_pc   (rpc),
    .out_valid     (ov),
    .out_ready     (rdy),
    .out_pc        (opc),
    .out_instr     (oinstr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  assign idata = mem_f(ireq_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    rdv   = 1'b0;
    dok   = 1'b0;
    rdy   = 1'b0;
    #1;
    chk({tag, "_rst_ireq_valid_now"}, ireq_valid, 0);
    chk({tag, "_rst_out_valid_now"}, ov, 0);
    tick();
    tick();
    chk({tag, "_rst_ireq_valid"}, ireq_valid, 0);
    chk({tag, "_rst_out_valid"}, ov, 0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_pc;
    logic [63:0] prev_ia;
    logic        prev_iv;
    logic        prev_dok;
    logic        busy;
    int          lat;
    int          wcnt;
    int          pops;

    // rdy is the out_ready applied after the row's comparison
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h04};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h08};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h0c};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h10};
    tbl[5]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h10};
    tbl[6]  = '{1'b1, 1'b1, 8'h04, 1'b1, 8'h10};
    tbl[7]  = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h14};
    tbl[8]  = '{1'b1, 1'b1, 8'h0c, 1'b1, 8'h18};
    tbl[9]  = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h1c};
    tbl[10] = '{1'b1, 1'b1, 8'h14, 1'b1, 8'h20};
    tbl[11] = '{1'b1, 1'b1, 8'h18, 1'b1, 8'h24};
    tbl[12] = '{1'b1, 1'b1, 8'h1c, 1'b1, 8'h28};

    // Table: zero-latency memory, fill to full, drain one, then stream
    do_reset("tbl");
    tick();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_out_valid", i), ov, tbl[i].ov);
      chk($sformatf("tbl%0d_ireq_valid", i), ireq_valid, tbl[i].iv);
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_pc", i), opc, BASE + 64'(tbl[i].pc_off));
        chk($sformatf("tbl%0d_out_instr", i), oinstr, mem_f(BASE + 64'(tbl[i].pc_off)));
      end
      if (tbl[i].iv) chk($sformatf("tbl%0d_ireq_addr", i), ireq_addr, BASE + 64'(tbl[i].ia_off));
      rdy = tbl[i].rdy;
      dok = ireq_valid;
      tick();
    end

    // Redirect with data_ok and pop together, then redirect while full in IDLE
    do_reset("flush");
    tick();
    dok = 1'b1;
    tick();
    tick();
    tick();
    chk("flush_pre_valid", ov, 1);
    chk("flush_pre_pc", opc, BASE);
    rdy = 1'b1;
    rdv = 1'b1;
    rpc = BASE + 64'h1000;
    tick();
    rdv = 1'b0;
    rdy = 1'b0;
    chk("flush_count0", ov, 0);
    chk("flush_ireq_valid", ireq_valid, 1);
    chk("flush_ireq_addr", ireq_addr, BASE + 64'h1000);
    tick();
    chk("flush_first_valid", ov, 1);
    chk("flush_first_pc", opc, BASE + 64'h1000);
    chk("flush_first_instr", oinstr, mem_f(BASE + 64'h1000));
    tick();
    tick();
    tick();
    chk("full_idle", ireq_valid, 0);
    chk("full_head_pc", opc, BASE + 64'h1000);
    dok = 1'b0;
    rdy = 1'b1;
    rdv = 1'b1;
    rpc = BASE + 64'h2003;
    tick();
    rdv = 1'b0;
    rdy = 1'b0;
    chk("idle_redir_empty", ov, 0);
    chk("idle_redir_valid", ireq_valid, 1);
    chk("idle_redir_addr", ireq_addr, BASE + 64'h2000);

    // Redirect while the response is delayed: stale data dropped
    do_reset("disc");
    rdy = 1'b1;
    tick();
    chk("disc_req_addr", ireq_addr, BASE);
    rdv = 1'b1;
    rpc = BASE + 64'h1002;
    tick();
    rdv = 1'b0;
    chk("disc_w1_valid", ireq_valid, 1);
    chk("disc_w1_addr", ireq_addr, BASE);
    chk("disc_w1_empty", ov, 0);
    tick();
    chk("disc_w2_addr", ireq_addr, BASE);
    chk("disc_w2_empty", ov, 0);
    dok = 1'b1;
    tick();
    dok = 1'b0;
    chk("disc_drop_empty", ov, 0);
    chk("disc_new_valid", ireq_valid, 1);
    chk("disc_new_addr", ireq_addr, BASE + 64'h1000);
    dok = 1'b1;
    tick();
    dok = 1'b0;
    chk("disc_first_pc", opc, BASE + 64'h1000);
    chk("disc_first_valid", ov, 1);

    // Reset asserted while a stale fetch is outstanding
    do_reset("rd");
    tick();
    rdv = 1'b1;
    rpc = BASE + 64'h3000;
    tick();
    rdv = 1'b0;
    chk("rd_in_discard_valid", ireq_valid, 1);
    chk("rd_in_discard_addr", ireq_addr, BASE);
    do_reset("rd_mid");
    rdy = 1'b1;
    tick();
    chk("rd_restart_valid", ireq_valid, 1);
    chk("rd_restart_addr", ireq_addr, BASE);
    dok = 1'b1;
    tick();
    dok = 1'b0;
    chk("rd_restart_out_valid", ov, 1);
    chk("rd_restart_out_pc", opc, BASE);

    // Random: stream model of consumed PCs plus bus-hold rule
    do_reset("rand");
    exp_pc   = BASE;
    prev_iv  = 1'b0;
    prev_dok = 1'b0;
    prev_ia  = '0;
    busy     = 1'b0;
    lat      = 0;
    wcnt     = 0;
    pops     = 0;
    for (int c = 0; c < 600; c++) begin
      if (prev_iv && !prev_dok) begin
        chk("rand_hold_valid", ireq_valid, 1);
        chk("rand_hold_addr", ireq_addr, prev_ia);
      end
      rdy = ($urandom_range(0, 3) != 0);
      rdv = ($urandom_range(0, 24) == 0);
      if (rdv) begin
        if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
        else                           rpc = BASE | 64'($urandom_range(0, 4095));
      end
      if (ireq_valid) begin
        if (!busy) begin
          busy = 1'b1;
          lat  = $urandom_range(0, 3);
          wcnt = 0;
        end
        if (wcnt == lat) begin
          dok  = 1'b1;
          busy = 1'b0;
        end else begin
          dok  = 1'b0;
          wcnt++;
        end
      end else begin
        dok = 1'b0;
      end
      if (ov && rdy && !rdv) begin
        chk("rand_out_pc", opc, exp_pc);
        chk("rand_out_instr", oinstr, mem_f(exp_pc));
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
      if (rdv) exp_pc = rpc & ~64'h3;
      prev_iv  = ireq_valid;
      prev_ia  = ireq_addr;
      prev_dok = dok;
      tick();
    end
    rdv = 1'b0;
    dok = 1'b0;
    chk("rand_pops_min", pops >= 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
